// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full adder time-shared LSB-first over WIDTH cycles,
// sequenced by an IDLE/RUN/DONE controller with registered sum/cout/ovf.
module serial_add_fa (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ c;
    assign co = (x & y) | (x & c) | (y & c);
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr, b_sr, psum;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_c;
    logic             last;

    serial_add_fa u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .c  (carry),
        .s  (fa_s),
        .co (fa_c)
    );

    // Counter is not advanced on the last bit, so a power-of-two WIDTH never wraps it.
    assign last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            psum  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_sr  <= a;
                    b_sr  <= b;
                    carry <= cin;
                    psum  <= '0;
                    cnt   <= '0;
                    state <= RUN;
                end
                RUN: begin
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    psum  <= {fa_s, psum[WIDTH-1:1]};
                    carry <= fa_c;
                    if (last) begin
                        // carry flop still holds the carry into the MSB here
                        sum   <= {fa_s, psum[WIDTH-1:1]};
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench: WIDTH=8 instance for timing/corner cases, WIDTH=3 for exhaustive sweep.
module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0, cin8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       busy8, done8, cout8, ovf8;
    logic       start3 = 1'b0, cin3 = 1'b0;
    logic [2:0] a3 = '0, b3 = '0, sum3;
    logic       busy3, done3, cout3, ovf3;

    int n_cmp = 0;
    int n_err = 0;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
    );

    serial_add_ctrl #(.WIDTH(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3), .ovf(ovf3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // exp = {ovf, cout, sum}
    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input logic [9:0] exp);
        int n;
        a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        n = 0;
        while (!done8 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, ".lat"}, n, 8);
        chk({tag, ".res"}, {ovf8, cout8, sum8}, exp);
        tick();
        chk({tag, ".done_off"}, done8, 0);
    endtask

    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic c);
        int n;
        logic [3:0] exp;
        exp = 4'(a) + 4'(b) + 4'(c);
        a3 = a; b3 = b; cin3 = c; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        n = 0;
        while (!done3 && n < 10) begin
            tick();
            n++;
        end
        chk($sformatf("w3.%0d+%0d+%0d", a, b, c), {n[3:0], cout3, sum3}, {4'd3, exp});
        tick();
    endtask

    initial begin
        int nd, cyc, idx;
        int t[3];
        logic [7:0] oa[3], ob[3];
        logic [9:0] oe[3];

        // reset state
        tick();
        chk("rst.busy", busy8, 0);
        chk("rst.done", done8, 0);
        chk("rst.res", {ovf8, cout8, sum8}, 0);
        chk("rst.w3", {busy3, done3, ovf3, cout3, sum3}, 0);

        // start sampled while rst_n still low is ignored; once released it is accepted
        a8 = 8'd3; b8 = 8'd5; cin8 = 1'b0; start8 = 1'b1;
        tick();
        chk("rst.start_ign", busy8, 0);
        rst_n = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("basic.busy%0d", i + 1), {busy8, done8}, 2'b10);
            tick();
        end
        chk("basic.done", {busy8, done8}, 2'b01);
        chk("basic.res", {ovf8, cout8, sum8}, 10'h008);
        tick();
        chk("basic.idle", {busy8, done8}, 2'b00);

        run8("ff+01", 8'hFF, 8'h01, 1'b0, 10'h100);
        run8("7f+01", 8'h7F, 8'h01, 1'b0, 10'h280);
        run8("80+80", 8'h80, 8'h80, 1'b0, 10'h300);
        run8("ff+00+c", 8'hFF, 8'h00, 1'b1, 10'h100);
        run8("a5+5a+c", 8'hA5, 8'h5A, 1'b1, 10'h100);
        run8("3c+41", 8'h3C, 8'h41, 1'b0, 10'h07D);

        // start re-pulsed during RUN and at the DONE edge must be ignored
        a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        tick();
        tick();
        chk("busy_ign.hold", {ovf8, cout8, sum8}, 10'h07D);
        a8 = 8'd1; b8 = 8'd2; cin8 = 1'b1; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        a8 = 8'hEE; b8 = 8'hEE;
        nd = 0;
        for (int i = 0; i < 20; i++) begin
            if (done8) begin
                nd++;
                chk("busy_ign.res", {ovf8, cout8, sum8}, 10'h01E);
            end
            start8 = done8;
            tick();
        end
        start8 = 1'b0;
        chk("busy_ign.pulses", nd, 1);

        // asynchronous reset at RUN bit 4
        a8 = 8'h55; b8 = 8'h0F; cin8 = 1'b0; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("mid_rst.busy_pre", busy8, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.busy", busy8, 0);
        chk("mid_rst.res", {done8, ovf8, cout8, sum8}, 0);
        tick();
        rst_n = 1'b1;
        nd = 0;
        for (int i = 0; i < 15; i++) begin
            if (done8) nd++;
            tick();
        end
        chk("mid_rst.no_done", nd, 0);
        run8("post_rst", 8'h55, 8'h0F, 1'b0, 10'h064);

        // start held high: three back-to-back operations
        oa[0] = 8'h01; ob[0] = 8'h02; oe[0] = 10'h003;
        oa[1] = 8'hF0; ob[1] = 8'h20; oe[1] = 10'h110;
        oa[2] = 8'h40; ob[2] = 8'h40; oe[2] = 10'h280;
        a8 = oa[0]; b8 = ob[0]; cin8 = 1'b0; start8 = 1'b1;
        cyc = 0; idx = 0;
        while (idx < 3 && cyc < 60) begin
            tick();
            cyc++;
            if (done8) begin
                t[idx] = cyc;
                chk($sformatf("b2b.res%0d", idx), {ovf8, cout8, sum8}, oe[idx]);
                idx++;
                if (idx < 3) begin
                    a8 = oa[idx]; b8 = ob[idx];
                end else begin
                    start8 = 1'b0;
                end
            end
        end
        start8 = 1'b0;
        chk("b2b.count", idx, 3);
        if (idx == 3) begin
            chk("b2b.gap01", t[1] - t[0], 10);
            chk("b2b.gap12", t[2] - t[1], 10);
        end
        tick();
        tick();

        // exhaustive WIDTH=3 sweep
        for (int ia = 0; ia < 8; ia++)
            for (int ib = 0; ib < 8; ib++)
                for (int ic = 0; ic < 2; ic++)
                    run3(3'(ia), 3'(ib), 1'(ic));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
